sdram_rd_fifo: RTL and testbench

Read-side DMA engine in the `sdram_clk` domain, the counterpart of the FIFO-to-SDRAM writer. On a `start` pulse it reads a region of SDRAM in fixed-length bursts through the controller's read port. It pushes the returned words into the downstream FIFO feeding the USB/Cypress side. A burst is requested only when the FIFO has room for the whole burst.

---
 rtl/sdram_rd_pkg.sv | 7 +
 rtl/sdram_rd_fifo.sv | 127 ++++++++++++
 tb/tb_sdram_rd_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_rd_pkg.sv
// sdram_rd_pkg: state encoding and default constants shared by the SDRAM read DMA.
package sdram_rd_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CHK_SPACE, S_REQ, S_RECV, S_DONE} state_e;
    localparam int BURST_LEN_DEF    = 8;
    localparam int ADDR_STEP_DEF    = 2;
    localparam int TIMEOUT_CLKS_DEF = 255;
endpackage

// File: rtl/sdram_rd_fifo.sv
// sdram_rd_fifo: reads an SDRAM region in fixed bursts and pushes the words into a downstream FIFO.
module sdram_rd_fifo
    import sdram_rd_pkg::*;
#(
    parameter int BURST_LEN    = BURST_LEN_DEF,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int ADDR_STEP    = ADDR_STEP_DEF,
    parameter int LEN_W        = 24,
    parameter int SPACE_W      = 10,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic              sdram_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_stray,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              fifo_wen,
    output logic [DATA_W-1:0] fifo_wdata,
    input  logic [SPACE_W-1:0] fifo_wspace
);
    localparam int BL_SH  = $clog2(BURST_LEN);
    localparam int BEAT_W = BL_SH + 1;
    localparam int WD_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * ADDR_STEP);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]    bursts_q, bursts_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_timeout_q, err_timeout_d, err_stray_q, err_stray_d;
    logic                fifo_wen_q;
    logic [DATA_W-1:0]   fifo_wdata_q;
    logic                accept, last_beat, timeout;
    logic [LEN_W-1:0]    start_bursts;

    assign accept       = state_q == S_IDLE && start && !abort;
    assign start_bursts = len_words >> BL_SH;
    assign last_beat    = state_q == S_RECV && rd_data_valid && beat_q == BEAT_W'(BURST_LEN - 1);
    assign timeout      = state_q == S_RECV && !rd_data_valid && wd_q == WD_W'(TIMEOUT_CLKS - 1);

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_addr_q    <= '0;
            bursts_q      <= '0;
            beat_q        <= '0;
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
            err_stray_q   <= 1'b0;
            fifo_wen_q    <= 1'b0;
            fifo_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            bursts_q      <= bursts_d;
            beat_q        <= beat_d;
            wd_q          <= wd_d;
            err_timeout_q <= err_timeout_d;
            err_stray_q   <= err_stray_d;
            fifo_wen_q    <= rd_data_valid && state_q == S_RECV;
            fifo_wdata_q  <= rd_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        bursts_d      = bursts_q;
        beat_d        = beat_q;
        wd_d          = wd_q;
        err_timeout_d = accept ? 1'b0 : err_timeout_q;
        // Beats outside S_RECV (e.g. still in flight after an abort) are dropped and flagged.
        err_stray_d   = (accept ? 1'b0 : err_stray_q) | (rd_data_valid && state_q != S_RECV);
        case (state_q)
            S_IDLE: if (accept) begin
                cur_addr_d = start_addr;
                bursts_d   = start_bursts;
                state_d    = start_bursts == '0 ? S_DONE : S_CHK_SPACE;
            end
            S_CHK_SPACE: if (fifo_wspace >= SPACE_W'(BURST_LEN)) state_d = S_REQ;
            S_REQ: if (rd_ready) begin
                cur_addr_d = cur_addr_q + BURST_BYTES;
                beat_d     = '0;
                wd_d       = '0;
                state_d    = S_RECV;
            end
            S_RECV: begin
                beat_d = beat_q + BEAT_W'(rd_data_valid);
                wd_d   = rd_data_valid ? '0 : wd_q + 1'b1;
                if (last_beat) begin
                    bursts_d = bursts_q - 1'b1;
                    state_d  = bursts_q == LEN_W'(1) ? S_DONE : S_CHK_SPACE;
                end else if (timeout) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        busy    = state_q != S_IDLE;
        done    = state_q == S_DONE;
        rd_req  = state_q == S_REQ;
        rd_addr = cur_addr_q;
    end

    assign err_timeout = err_timeout_q;
    assign err_stray   = err_stray_q;
    assign fifo_wen    = fifo_wen_q;
    assign fifo_wdata  = fifo_wdata_q;
endmodule

// File: tb/tb_sdram_rd_fifo.sv
// tb_sdram_rd_fifo: directed bench for the SDRAM read DMA with immediate-assertion checks.
module tb_sdram_rd_fifo;
    logic        sdram_clk, rst, start, abort, rd_ready, rd_data_valid;
    logic [31:0] start_addr, rd_addr;
    logic [23:0] len_words;
    logic        busy, done, err_timeout, err_stray, rd_req, fifo_wen;
    logic [15:0] rd_data, fifo_wdata;
    logic [9:0]  fifo_wspace;

    int checks = 0;
    int errors = 0;
    logic [15:0] wq[$];
    logic [31:0] aq[$];
    int done_cnt = 0;

    sdram_rd_fifo dut (
        .sdram_clk(sdram_clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .len_words(len_words), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_stray(err_stray), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
        .fifo_wspace(fifo_wspace)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    // Records writes, accepted requests and done pulses between edges.
    always @(negedge sdram_clk) begin
        if (!rst) begin
            if (fifo_wen) wq.push_back(fifo_wdata);
            if (rd_req && rd_ready) aq.push_back(rd_addr);
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [23:0] l);
        start_addr = a;
        len_words  = l;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (!rd_req && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, rd_req, 1);
        chk({tag, "_addr"}, rd_addr, exp_addr);
    endtask

    task automatic send_beats(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            rd_data       = base + 16'(i);
            rd_data_valid = 1'b1;
            tick();
        end
        rd_data_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        int w0, a0, d0;
        logic bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b1; rd_data_valid = 1'b0;
        start_addr = '0; len_words = '0; rd_data = '0; fifo_wspace = 10'd64;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", rd_req, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_wen", fifo_wen, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_errs", {err_timeout, err_stray}, 0);
        rst = 1'b0;
        tick();

        // Basic transfer: two bursts at 0x100 and 0x110.
        w0 = wq.size(); a0 = aq.size(); d0 = done_cnt;
        start_xfer(32'h100, 24'd16);
        chk("basic_busy_c1", busy, 1);
        chk("basic_noreq_c1", rd_req, 0);
        tick();
        chk("basic_req_c2", rd_req, 1);
        chk("basic_addr_c2", rd_addr, 32'h100);
        tick();
        tick(); tick();
        send_beats(8, 16'h1000);
        wait_req("basic2", 32'h110);
        tick();
        send_beats(8, 16'h1008);
        chk("basic_done", done, 1);
        chk("basic_last_wen", fifo_wen, 1);
        chk("basic_last_wdata", fifo_wdata, 16'h100F);
        tick();
        chk("basic_idle", busy, 0);
        tick();
        chk("basic_nwr", wq.size() - w0, 16);
        bad = 1'b0;
        for (int i = 0; i < 16; i++) if (wq[w0 + i] !== 16'h1000 + 16'(i)) bad = 1'b1;
        chk("basic_order", bad, 0);
        chk("basic_nreq", aq.size() - a0, 2);
        chk("basic_req0", aq[a0], 32'h100);
        chk("basic_req1", aq[a0 + 1], 32'h110);
        chk("basic_ndone", done_cnt - d0, 1);

        // Backpressure; a start while busy must be ignored.
        fifo_wspace = 10'd7;
        a0 = aq.size();
        start_xfer(32'h200, 24'd8);
        repeat (4) tick();
        start_xfer(32'h900, 24'd8);
        repeat (4) tick();
        chk("bp_noreq", rd_req, 0);
        chk("bp_nreq", aq.size() - a0, 0);
        rd_ready = 1'b0;
        fifo_wspace = 10'd8;
        tick();
        chk("bp_req", rd_req, 1);
        tick();
        chk("bp_hold_req", rd_req, 1);
        chk("bp_hold_addr", rd_addr, 32'h200);
        rd_ready = 1'b1;
        tick();
        chk("bp_accepted", rd_req, 0);
        send_beats(8, 16'h2000);
        chk("bp_done", done, 1);
        tick();
        fifo_wspace = 10'd64;

        // Zero-burst length and odd length.
        a0 = aq.size(); d0 = done_cnt;
        start_xfer(32'h300, 24'd5);
        wait_done("zero_done", 1);
        tick(); tick();
        chk("zero_noreq", aq.size() - a0, 0);
        chk("zero_ndone", done_cnt - d0, 1);
        a0 = aq.size();
        start_xfer(32'h400, 24'd13);
        wait_req("odd", 32'h400);
        tick();
        send_beats(8, 16'h4000);
        chk("odd_done", done, 1);
        tick(); tick();
        chk("odd_nreq", aq.size() - a0, 1);

        // Address wrap.
        start_xfer(32'hFFFF_FFF8, 24'd16);
        wait_req("wrap1", 32'hFFFF_FFF8);
        tick();
        send_beats(8, 16'h5000);
        wait_req("wrap2", 32'h0000_0008);
        tick();
        send_beats(8, 16'h5008);
        chk("wrap_done", done, 1);
        tick(); tick();

        // Abort mid-burst, then stray beats.
        w0 = wq.size(); d0 = done_cnt;
        start_xfer(32'h600, 24'd8);
        wait_req("abort", 32'h600);
        tick();
        send_beats(3, 16'h6000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        send_beats(5, 16'h6003);
        tick(); tick();
        chk("abort_nwr", wq.size() - w0, 3);
        chk("abort_stray", err_stray, 1);
        chk("abort_nodone", done_cnt - d0, 0);
        start_xfer(32'h700, 24'd0);
        chk("stray_cleared", err_stray, 0);
        tick(); tick();

        // Watchdog timeout.
        d0 = done_cnt;
        start_xfer(32'h800, 24'd8);
        wait_req("tmo", 32'h800);
        tick();
        repeat (254) tick();
        chk("tmo_still_busy", busy, 1);
        chk("tmo_not_yet", err_timeout, 0);
        tick();
        chk("tmo_idle", busy, 0);
        chk("tmo_err", err_timeout, 1);
        tick();
        chk("tmo_nodone", done_cnt - d0, 0);

        // Reset mid-transfer.
        start_xfer(32'hA00, 24'd8);
        chk("rst_mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_idle", busy, 0);
        chk("rst_mid_addr", rd_addr, 0);
        chk("rst_mid_err", err_timeout, 0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
